// File: rtl/sdp_ram_arbiter_if.sv
// Requester-side bus of the simple-dual-port RAM arbiter: two write ports,
// two read ports and the shared read-response return path.
interface sdp_ram_arbiter_if #(
    parameter int unsigned NB_COL    = 8,
    parameter int unsigned COL_WIDTH = 8,
    parameter int unsigned AW        = 9
);
    localparam int unsigned DW = NB_COL * COL_WIDTH;

    logic [1:0]        wr_valid;
    logic [2*AW-1:0]   wr_addr;
    logic [2*DW-1:0]   wr_data;
    logic [2*NB_COL-1:0] wr_be;
    logic [1:0]        wr_ready;

    logic [1:0]        rd_valid;
    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        rd_ready;

    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_data;

    // Requester side (fill/drain engines)
    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        input  wr_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  rsp_valid, rsp_data
    );

    // Arbiter side
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        output wr_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/sdp_ram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port byte-write RAM between two
// writers and two readers. Read results are routed back through a tag pipeline
// whose depth equals the RAM read latency.
module sdp_ram_arbiter #(
    parameter int unsigned NB_COL     = 8,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned RAM_DEPTH  = 512,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned AW        = $clog2(RAM_DEPTH),
    localparam int unsigned DW        = NB_COL * COL_WIDTH
) (
    input  logic              clka,
    input  logic              rstb,
    sdp_ram_arbiter_if.slave  bus,
    output logic [AW-1:0]     ram_addra,
    output logic [DW-1:0]     ram_dina,
    output logic [NB_COL-1:0] ram_wea,
    output logic [AW-1:0]     ram_addrb,
    output logic              ram_enb,
    output logic              ram_rstb,
    input  logic [DW-1:0]     ram_doutb
);

    logic                  wr_pri_q;   // 1: requester 1 wins next write contention
    logic                  rd_pri_q;   // 1: requester 1 wins next read contention
    logic                  rd_sel_q;   // last issued read requester, holds ram_addrb
    logic [1:0]            wr_gnt;
    logic [1:0]            rd_gnt;
    logic                  rd_issue;
    logic                  rd_sel;
    logic [RD_LATENCY-1:0] tag_v_q;
    logic [RD_LATENCY-1:0] tag_id_q;
    logic                  tag_pend;

    // Write grant: single requester wins outright, contention follows wr_pri_q
    always_comb begin
        wr_gnt = 2'b00;
        if (!rstb) begin
            case (bus.wr_valid)
                2'b01:   wr_gnt = 2'b01;
                2'b10:   wr_gnt = 2'b10;
                2'b11:   wr_gnt = wr_pri_q ? 2'b10 : 2'b01;
                default: wr_gnt = 2'b00;
            endcase
        end
    end

    // Read grant: same scheme with its own priority bit
    always_comb begin
        rd_gnt = 2'b00;
        if (!rstb) begin
            case (bus.rd_valid)
                2'b01:   rd_gnt = 2'b01;
                2'b10:   rd_gnt = 2'b10;
                2'b11:   rd_gnt = rd_pri_q ? 2'b10 : 2'b01;
                default: rd_gnt = 2'b00;
            endcase
        end
    end

    // RAM port A drive from the granted writer; no grant means no byte enables
    always_comb begin
        ram_addra = wr_gnt[1] ? bus.wr_addr[AW +: AW] : bus.wr_addr[0 +: AW];
        ram_dina  = wr_gnt[1] ? bus.wr_data[DW +: DW] : bus.wr_data[0 +: DW];
        ram_wea   = '0;
        if (wr_gnt[1])      ram_wea = bus.wr_be[NB_COL +: NB_COL];
        else if (wr_gnt[0]) ram_wea = bus.wr_be[0 +: NB_COL];
    end

    // RAM port B drive; idle cycles keep the previous requester's address selected
    always_comb begin
        rd_issue  = |rd_gnt;
        rd_sel    = rd_issue ? rd_gnt[1] : rd_sel_q;
        ram_addrb = rd_sel ? bus.rd_addr[AW +: AW] : bus.rd_addr[0 +: AW];
        tag_pend  = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
            tag_pend = tag_pend | tag_v_q[i];
        end
        // Keep enb high while data is still moving toward the output register
        ram_enb   = rd_issue | tag_pend;
    end

    // Response strobe comes from the last tag stage; data is the RAM output as-is
    always_comb begin
        bus.rsp_valid = 2'b00;
        if (tag_v_q[RD_LATENCY-1] && !rstb) begin
            bus.rsp_valid = tag_id_q[RD_LATENCY-1] ? 2'b10 : 2'b01;
        end
        bus.rsp_data = ram_doutb;
        bus.wr_ready = wr_gnt;
        bus.rd_ready = rd_gnt;
        ram_rstb     = rstb;
    end

    // Priority bits flip only on contended cycles; reset favours requester 0
    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_pri_q <= 1'b0;
            rd_pri_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (&bus.wr_valid) wr_pri_q <= ~wr_gnt[1];
            if (&bus.rd_valid) rd_pri_q <= ~rd_gnt[1];
            if (rd_issue)      rd_sel_q <= rd_gnt[1];
        end
    end

    // Tag shift register tracking reads in flight; reset drops them all
    always_ff @(posedge clka) begin
        if (rstb) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q[0]  <= rd_issue;
            tag_id_q[0] <= rd_gnt[1];
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed bench for sdp_ram_arbiter with a behavioural 2-cycle SDP RAM and a
// scoreboard of expected read responses checked by an independent monitor.
module tb_sdp_ram_arbiter;
    localparam int unsigned NB_COL = 8;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned LAT    = 2;
    localparam int unsigned AW     = 9;
    localparam int unsigned DW     = 64;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic              clka = 1'b0;
    logic              rstb = 1'b1;
    logic [AW-1:0]     ram_addra;
    logic [DW-1:0]     ram_dina;
    logic [NB_COL-1:0] ram_wea;
    logic [AW-1:0]     ram_addrb;
    logic              ram_enb;
    logic              ram_rstb;
    logic [DW-1:0]     ram_doutb;
    logic [DW-1:0]     ram_q;
    logic [DW-1:0]     mem [DEPTH];

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    sdp_ram_arbiter_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_W), .AW(AW)) bus ();

    sdp_ram_arbiter #(
        .NB_COL     (NB_COL),
        .COL_WIDTH  (COL_W),
        .RAM_DEPTH  (DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .clka      (clka),
        .rstb      (rstb),
        .bus       (bus.slave),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_rstb  (ram_rstb),
        .ram_doutb (ram_doutb)
    );

    always #5 clka = ~clka;

    // Cycle counter: value k holds between posedge k and posedge k+1
    always @(posedge clka) cyc <= cyc + 1;

    // Behavioural RAM: byte-write port A, read with address and output registers
    always @(posedge clka) begin
        for (int b = 0; b < NB_COL; b++) begin
            if (ram_wea[b]) mem[ram_addra][b*COL_W +: COL_W] <= ram_dina[b*COL_W +: COL_W];
        end
        if (ram_enb) ram_q <= mem[ram_addrb];
        if (ram_rstb)     ram_doutb <= '0;
        else if (ram_enb) ram_doutb <= ram_q;
    end

    // Monitor: every response strobe must match the oldest expected entry
    always @(negedge clka) begin
        if (bus.rsp_valid !== 2'b00) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: rsp_valid=%b data=%h cycle=%0d, required no response",
                         bus.rsp_valid, bus.rsp_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.rsp_valid !== e.id || bus.rsp_data !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL rsp: got id=%b data=%h cycle=%0d, required id=%b data=%h cycle=%0d",
                             bus.rsp_valid, bus.rsp_data, cyc, e.id, e.data, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Check grants mid-cycle, queue the expected read response, advance one cycle
    task automatic step(input logic [1:0] exp_wr, input logic [1:0] exp_rd,
                        input logic [DW-1:0] exp_data, input bit push);
        logic [NB_COL-1:0] exp_wea;
        exp_t e;
        #3;
        chk("wr_ready", 64'(bus.wr_ready), 64'(exp_wr));
        chk("rd_ready", 64'(bus.rd_ready), 64'(exp_rd));
        exp_wea = exp_wr[1] ? bus.wr_be[15:8] : (exp_wr[0] ? bus.wr_be[7:0] : 8'h00);
        chk("ram_wea", 64'(ram_wea), 64'(exp_wea));
        chk("ram_rstb", 64'(ram_rstb), 64'(rstb));
        if (push) begin
            e.id   = exp_rd;
            e.data = exp_data;
            e.due  = cyc + LAT;
            q.push_back(e);
        end
        @(posedge clka);
        #1;
    endtask

    task automatic idle(input int n);
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b00;
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, 1'b0);
    endtask

    task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB_COL-1:0] be);
        if (r == 0) begin
            bus.wr_addr[8:0]   = a;
            bus.wr_data[63:0]  = d;
            bus.wr_be[7:0]     = be;
        end else begin
            bus.wr_addr[17:9]  = a;
            bus.wr_data[127:64] = d;
            bus.wr_be[15:8]    = be;
        end
    endtask

    task automatic set_rd(input int r, input logic [AW-1:0] a);
        if (r == 0) bus.rd_addr[8:0] = a;
        else        bus.rd_addr[17:9] = a;
    endtask

    initial begin
        bus.wr_valid = 2'b11;
        bus.rd_valid = 2'b11;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_be    = '1;
        bus.rd_addr  = '0;
        @(posedge clka);
        #1;
        // Reset: no grants even with every request raised
        step(2'b00, 2'b00, '0, 1'b0);
        step(2'b00, 2'b00, '0, 1'b0);
        rstb = 1'b0;
        idle(1);

        // Zero the words used later, through writer 1
        bus.wr_valid = 2'b10;
        set_wr(1, 9'd0, '0, 8'hFF); step(2'b10, 2'b00, '0, 1'b0);
        set_wr(1, 9'd7, '0, 8'hFF); step(2'b10, 2'b00, '0, 1'b0);
        set_wr(1, 9'd9, '0, 8'hFF); step(2'b10, 2'b00, '0, 1'b0);

        // Single read through rd1
        bus.wr_valid = 2'b01;
        set_wr(0, 9'd3, {8{8'hA5}}, 8'hFF); step(2'b01, 2'b00, '0, 1'b0);
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b10;
        set_rd(1, 9'd3); step(2'b00, 2'b10, {8{8'hA5}}, 1'b1);
        idle(3);

        // Contended reads: alternate starting with requester 0
        bus.rd_valid = 2'b11;
        set_rd(0, 9'd3);
        set_rd(1, 9'd0);
        step(2'b00, 2'b01, {8{8'hA5}}, 1'b1);
        step(2'b00, 2'b10, 64'h0, 1'b1);
        step(2'b00, 2'b01, {8{8'hA5}}, 1'b1);
        step(2'b00, 2'b10, 64'h0, 1'b1);
        idle(3);

        // Contended writes to one address: wr0 then wr1, last write wins
        bus.wr_valid = 2'b11;
        set_wr(0, 9'd5, {8{8'h11}}, 8'hFF);
        set_wr(1, 9'd5, {8{8'h22}}, 8'hFF);
        step(2'b01, 2'b00, '0, 1'b0);
        step(2'b10, 2'b00, '0, 1'b0);
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b01;
        set_rd(0, 9'd5); step(2'b00, 2'b01, {8{8'h22}}, 1'b1);
        idle(3);

        // Partial byte enable on a zeroed word
        bus.wr_valid = 2'b01;
        set_wr(0, 9'd9, {8{8'hFF}}, 8'h01); step(2'b01, 2'b00, '0, 1'b0);
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b10;
        set_rd(1, 9'd9); step(2'b00, 2'b10, 64'h0000_0000_0000_00FF, 1'b1);
        idle(3);

        // Same-cycle write/read collision returns old data
        bus.wr_valid = 2'b01;
        bus.rd_valid = 2'b01;
        set_wr(0, 9'd7, {8{8'h33}}, 8'hFF);
        set_rd(0, 9'd7);
        step(2'b01, 2'b01, 64'h0, 1'b1);
        bus.wr_valid = 2'b00;
        step(2'b00, 2'b01, {8{8'h33}}, 1'b1);
        idle(3);

        // Reset right after a read issue: the response must never appear
        bus.rd_valid = 2'b01;
        set_rd(0, 9'd3);
        step(2'b00, 2'b01, '0, 1'b0);
        bus.rd_valid = 2'b00;
        rstb = 1'b1;
        step(2'b00, 2'b00, '0, 1'b0);
        step(2'b00, 2'b00, '0, 1'b0);
        rstb = 1'b0;
        idle(4);
        bus.rd_valid = 2'b11;
        set_rd(1, 9'd0);
        step(2'b00, 2'b01, {8{8'hA5}}, 1'b1);
        idle(4);

        // Every queued response must have been delivered
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_missing: %0d responses outstanding, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdp_ram_arbiter.md
Name: sdp_ram_arbiter

Overview:
- Shares one simple-dual-port, single-clock byte-write RAM between two write requesters and two read requesters.
- Arbitrates each RAM port independently with round-robin.
- Drives the RAM's address, enable and byte-enable pins.
- Tracks in-flight reads through a tag pipeline that matches the RAM read latency, and returns each read result to the requester that issued it.
- Sits between buffer-fill/drain engines and a RAM instance in the same clock domain.

Parameters:
NB_COL, 8, number of byte columns in a RAM word
COL_WIDTH, 8, bits per column
RAM_DEPTH, 512, RAM entries; AW = bw(RAM_DEPTH) from GLB_PARAM
RD_LATENCY, 2, RAM read latency in cycles from the enb/addrb cycle to valid doutb (2 = output register, 1 = no output register)

Ports:
clka  in  1  clock, all logic on the rising edge
rstb  in  1  reset, synchronous, active-high
wr_valid  in  2  per-requester write request
wr_addr  in  2*AW  write addresses; requester i uses slice [i*AW +: AW]
wr_data  in  2*NB_COL*COL_WIDTH  write data, sliced per requester
wr_be  in  2*NB_COL  byte enables, sliced per requester
wr_ready  out  2  one-hot write grant, combinational
rd_valid  in  2  per-requester read request
rd_addr  in  2*AW  read addresses, sliced per requester
rd_ready  out  2  one-hot read grant, combinational
rsp_valid  out  2  read response strobe, one per requester
rsp_data  out  NB_COL*COL_WIDTH  read data, shared by both requesters, qualified by rsp_valid
ram_addra  out  AW  RAM write address
ram_dina  out  NB_COL*COL_WIDTH  RAM write data
ram_wea  out  NB_COL  RAM byte write enable
ram_addrb  out  AW  RAM read address
ram_enb  out  1  RAM read enable
ram_rstb  out  1  RAM output reset, driven equal to rstb
ram_doutb  in  NB_COL*COL_WIDTH  RAM read data

Behaviour:
- Write arbitration (combinational, every cycle):
  - One requester valid: it is granted.
  - Both valid: grant the requester that did not win the last contended write.
  - wr_pri is a 1-bit register, updated only on cycles where both requesters were valid.
- Write drive:
  - Granted requester i: ram_wea = wr_be[i], ram_addra and ram_dina = requester i's slices.
  - No grant: ram_wea = 0; ram_addra and ram_dina are don't-care.
  - A write completes in the grant cycle; writes produce no response.
- Read arbitration: same round-robin scheme, using its own rd_pri register.
- Read issue:
  - A grant issues the read in that cycle: ram_addrb = granted address.
  - A tag (valid bit + requester id) enters a RD_LATENCY-deep shift register.
- Read response:
  - A tag leaving the shift register asserts rsp_valid[id] for exactly one cycle.
  - rsp_data = ram_doutb, exactly RD_LATENCY cycles after the grant.
- Read throughput and ordering:
  - Fully pipelined: one read per cycle; responses return in issue order.
  - There is no response backpressure; consumers must accept rsp_valid unconditionally.
- RAM enable:
  - ram_enb = read issued this cycle OR any valid tag in stages 0..RD_LATENCY-2.
  - This keeps the RAM output register loading while data is in flight.
- ram_addrb when idle: holds the last issued address. It is a registered mux select, so a stray enb re-read is harmless.
- Collision: a write and a read to the same address in the same cycle return the old data. No forwarding is done.
- Reset values:
  - wr_pri = rd_pri = 0, so requester 0 wins the first contention.
  - All tag valids = 0; rsp_valid = 0; ram_wea = 0.
  - wr_ready = rd_ready = 0 while rstb is high; no grants are issued during reset.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid follows. The RAM output is cleared via ram_rstb.

Test Plan:
- Single read: write 0xA5 to all bytes at addr 3 via wr0, then read addr 3 from rd1 → rsp_valid = 2'b10 exactly 2 cycles after the grant, rsp_data = all 0xA5.
- Contended reads: rd_valid = 2'b11 held for 4 cycles → rd_ready sequence 01, 10, 01, 10; responses alternate 01, 10, 01, 10 from grant+2 onward, back-to-back.
- Contended writes: wr0 writes addr 5 = 0x11, wr1 writes addr 5 = 0x22, both held → wr0 granted first, wr1 granted next; a subsequent read of addr 5 returns 0x22.
- Byte-enable: wr_be = 0x01 with data 0xFF..FF on a word pre-written to 0 → read returns 0x00..00FF.
- Collision: write addr 7 = 0x33 and read addr 7 in the same cycle, old value 0 → rsp_data = 0. A read of addr 7 on the next cycle → 0x33.
- Reset: issue a read, assert rstb one cycle later → no rsp_valid ever follows; after deassertion, rd_valid = 2'b11 → rd_ready = 2'b01.
